// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP_INSTR     : instruction presented when nothing is queued (also IF/ID reset value)
//   PC_STEP       : byte distance between sequential instructions
//   fetch_entry_t : one prefetched instruction word with the PC it was fetched from
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t used as the fetch prefetch queue.
//   clk, rst  : clock, asynchronous active-high reset (empties the queue)
//   push/data : write data at the tail
//   pop       : advance the head (ignored when empty)
//   flush     : discard all entries; dominates push and pop
//   head      : current head entry (meaningless while count == 0)
//   count     : number of stored entries, 0..DEPTH
module fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  // A push into a full queue is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch stage. Owns the PC, reads the instruction ROM (1-cycle
// latency) into a prefetch queue and presents the queue head to IF/ID.
//   clk          : clock, rising edge
//   R            : asynchronous active-high reset
//   LE           : IF/ID load enable; valid && LE consumes the head
//   br_taken     : single-cycle redirect request
//   br_target    : redirect byte address (bits [1:0] ignored)
//   rom_req      : ROM read strobe
//   rom_addr     : ROM byte address (low ROM_AW bits of the fetch PC)
//   rom_data     : ROM word, valid the cycle after rom_req
//   instruction  : queue head instruction, NOP when empty
//   pc_plus_4    : queue head PC + 4, zero when empty
//   valid        : queue non-empty
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned QDEPTH   = 2,
  parameter int unsigned ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              LE,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       instruction,
  output logic [31:0]       pc_plus_4,
  output logic              valid
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [31:0]   br_addr;
  logic [31:0]   req_addr;
  logic [CW:0]   occupancy;
  logic          pop;
  logic          push;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;
  logic          unused_br_lsbs;

  assign unused_br_lsbs = ^br_target[1:0];
  assign br_addr        = {br_target[31:2], 2'b00};

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (R),
    .push  (push),
    .data  (q_in),
    .pop   (pop),
    .flush (br_taken),
    .head  (q_head),
    .count (q_count)
  );

  // Entries already stored plus the word still in flight, minus the one leaving
  // this cycle, must stay below QDEPTH; this is what makes overflow impossible.
  always_comb begin
    valid     = (q_count != '0);
    pop       = valid && LE;
    push      = inflight && !br_taken;
    q_in      = '{instr: rom_data, pc: req_pc};
    occupancy = {1'b0, q_count} + (CW+1)'(inflight) - (CW+1)'(pop);
    req_addr  = br_taken ? br_addr : fetch_pc;
    rom_req   = !R && (br_taken || (occupancy < (CW+1)'(QDEPTH)));
    rom_addr  = req_addr[ROM_AW-1:0];
  end

  // The queue is cleared asynchronously by R, so these fall to zero with it.
  always_comb begin
    instruction = valid ? q_head.instr : NOP_INSTR;
    pc_plus_4   = valid ? (q_head.pc + PC_STEP) : '0;
  end

  // Clearing inflight on reset drops any word returning for a pre-reset request.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= rom_req;
      if (rom_req) begin
        fetch_pc <= req_addr + PC_STEP;
        req_pc   <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        r1, le, br;
  logic [31:0] tgt;
  logic        req1;
  logic [7:0]  addr1;
  logic [31:0] rd1, ins1, p41;
  logic        v1;

  logic        r2;
  logic        req2;
  logic [7:0]  addr2;
  logic [31:0] rd2, ins2, p42;
  logic        v2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (32'h0),
    .QDEPTH   (2),
    .ROM_AW   (8)
  ) dut (
    .clk         (clk),
    .R           (r1),
    .LE          (le),
    .br_taken    (br),
    .br_target   (tgt),
    .rom_req     (req1),
    .rom_addr    (addr1),
    .rom_data    (rd1),
    .instruction (ins1),
    .pc_plus_4   (p41),
    .valid       (v1)
  );

  if_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8),
    .QDEPTH   (2),
    .ROM_AW   (8)
  ) dut_wrap (
    .clk         (clk),
    .R           (r2),
    .LE          (1'b1),
    .br_taken    (1'b0),
    .br_target   (32'h0),
    .rom_req     (req2),
    .rom_addr    (addr2),
    .rom_data    (rd2),
    .instruction (ins2),
    .pc_plus_4   (p42),
    .valid       (v2)
  );

  // ROM: word at byte address a is a; junk when not requested.
  always @(posedge clk) begin
    rd1 <= req1 ? {24'h0, addr1} : 32'hDEAD_BEEF;
    rd2 <= req2 ? {24'h0, addr2} : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        r, le, br;
    logic [31:0] tgt;
    logic        req;
    logic [7:0]  addr;
    logic        v;
    logic [31:0] ins, p4;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic l, input logic b, input logic [31:0] t,
                              input logic q, input logic [7:0] a, input logic v,
                              input logic [31:0] i, input logic [31:0] p);
    vec_t x;
    x.r = r; x.le = l; x.br = b; x.tgt = t;
    x.req = q; x.addr = a; x.v = v; x.ins = i; x.p4 = p;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic rq, input logic [7:0] a, input logic v,
                      input logic [31:0] i, input logic [31:0] p);
    chk({nm, ".rom_req"},     {31'h0, req1}, {31'h0, rq});
    chk({nm, ".rom_addr"},    {24'h0, addr1}, {24'h0, a});
    chk({nm, ".valid"},       {31'h0, v1}, {31'h0, v});
    chk({nm, ".instruction"}, ins1, i);
    chk({nm, ".pc_plus_4"},   p41, p);
  endtask

  initial begin
    r1 = 1'b1; r2 = 1'b1; le = 1'b1; br = 1'b0; tgt = 32'h0;

    // reset, then streaming
    tbl.push_back(mk(1,1,0,0,       0,8'h00,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,       1,8'h00,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,       1,8'h04,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,       1,8'h08,1,32'h00,32'h04));
    tbl.push_back(mk(0,1,0,0,       1,8'h0C,1,32'h04,32'h08));
    tbl.push_back(mk(0,1,0,0,       1,8'h10,1,32'h08,32'h0C));
    // reset again, stall 5 cycles from the first valid
    tbl.push_back(mk(1,1,0,0,       0,8'h00,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,       1,8'h00,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,       1,8'h04,0,32'h00,32'h00));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,0,0,0,     0,8'h08,1,32'h00,32'h04));
    tbl.push_back(mk(0,1,0,0,       1,8'h08,1,32'h00,32'h04));
    tbl.push_back(mk(0,1,0,0,       1,8'h0C,1,32'h04,32'h08));
    tbl.push_back(mk(0,1,0,0,       1,8'h10,1,32'h08,32'h0C));
    // redirect to 0x40 with one queued and one in flight
    tbl.push_back(mk(0,1,1,32'h40,  1,8'h40,1,32'h0C,32'h10));
    tbl.push_back(mk(0,1,0,0,       1,8'h44,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,       1,8'h48,1,32'h40,32'h44));
    tbl.push_back(mk(0,1,0,0,       1,8'h4C,1,32'h44,32'h48));
    // misaligned redirect target
    tbl.push_back(mk(0,1,1,32'h43,  1,8'h40,1,32'h48,32'h4C));
    tbl.push_back(mk(0,1,0,0,       1,8'h44,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,       1,8'h48,1,32'h40,32'h44));
    tbl.push_back(mk(0,1,0,0,       1,8'h4C,1,32'h44,32'h48));
    // redirect while the queue is full and stalled
    tbl.push_back(mk(0,0,0,0,       0,8'h50,1,32'h48,32'h4C));
    tbl.push_back(mk(0,0,0,0,       0,8'h50,1,32'h48,32'h4C));
    tbl.push_back(mk(0,0,1,32'h80,  1,8'h80,1,32'h48,32'h4C));
    tbl.push_back(mk(0,0,0,0,       1,8'h84,0,32'h00,32'h00));
    tbl.push_back(mk(0,0,0,0,       0,8'h88,1,32'h80,32'h84));
    tbl.push_back(mk(0,1,0,0,       1,8'h88,1,32'h80,32'h84));
    tbl.push_back(mk(0,1,0,0,       1,8'h8C,1,32'h84,32'h88));

    foreach (tbl[n]) begin
      @(negedge clk);
      r1 = tbl[n].r; le = tbl[n].le; br = tbl[n].br; tgt = tbl[n].tgt;
      #1;
      chk1($sformatf("row%0d", n), tbl[n].req, tbl[n].addr, tbl[n].v, tbl[n].ins, tbl[n].p4);
    end

    // reset pulse between edges while streaming
    @(negedge clk);
    br = 1'b0; le = 1'b1;
    #1;
    chk1("pre_pulse", 1'b1, 8'h90, 1'b1, 32'h88, 32'h8C);
    @(negedge clk);
    #1 r1 = 1'b1;
    #1 chk1("pulse_high", 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    #1 r1 = 1'b0;
    #1 chk1("pulse_low", 1'b1, 8'h00, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk1("post_pulse0", 1'b1, 8'h04, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk1("post_pulse1", 1'b1, 8'h08, 1'b1, 32'h00, 32'h04);
    @(negedge clk); #1;
    chk1("post_pulse2", 1'b1, 8'h0C, 1'b1, 32'h04, 32'h08);

    // PC wrap with RESET_PC near the top of the address space
    @(negedge clk);
    r2 = 1'b0;
    #1;
    chk("wrap0.rom_addr", {24'h0, addr2}, 32'hF8);
    chk("wrap0.valid", {31'h0, v2}, 32'h0);
    @(negedge clk); #1;
    chk("wrap1.rom_addr", {24'h0, addr2}, 32'hFC);
    @(negedge clk); #1;
    chk("wrap2.rom_addr", {24'h0, addr2}, 32'h00);
    chk("wrap2.instruction", ins2, 32'hF8);
    chk("wrap2.pc_plus_4", p42, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap3.instruction", ins2, 32'hFC);
    chk("wrap3.pc_plus_4", p42, 32'h0);
    @(negedge clk); #1;
    chk("wrap4.instruction", ins2, 32'h00);
    chk("wrap4.pc_plus_4", p42, 32'h4);
    chk("wrap4.rom_req", {31'h0, req2}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
